tuner_ctrl_arb_mc_phy: RTL

// - Multi-channel controller arbiter PHY. NUM_CH ring controllers share one tuner-DAC write port and one power detector.
// - Round-robin grants one active channel at a time; each grant runs TUNE -> SYNC -> COMMIT.
// - Per-channel tune codes are held. Sync depth is runtime-programmable. A channel that drops out mid-grant is aborted.
// - Sits between the search/lock controllers and the tuner/power-detect AFE.

---
 rtl/tuner_phy_pkg.sv | 17 +
 rtl/tuner_rr_picker.sv | 29 ++
 rtl/tuner_ctrl_arb_mc_phy.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner PHY slice: arbiter FSM states and
// round-robin helper used to advance the grant pointer.
package tuner_phy_pkg;

  typedef enum logic [1:0] {
    ARB_MC_IDLE,
    ARB_MC_TUNE,
    ARB_MC_SYNC,
    ARB_MC_COMMIT
  } tuner_phy_ctrl_arb_mc_state_e;

  // Channel after ch, wrapping at n.
  function automatic int rr_next(input int ch, input int n);
    return (ch + 1) % n;
  endfunction

endpackage

// File: rtl/tuner_rr_picker.sv
// Combinational round-robin search: first set bit of req at or after ptr.
// Ports: req (per-channel request), ptr (start index), idx (winner), found.
module tuner_rr_picker #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  int c;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (req[c[CH_W-1:0]]) begin
        idx   = c[CH_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tuner_ctrl_arb_mc_phy.sv
// Multi-channel arbiter: NUM_CH ring controllers share one tuner-DAC write
// port and one power detector. Each grant runs TUNE -> SYNC -> COMMIT.
// Ports: i_ctrl_* / o_ctrl_* controller side (per channel, one-hot to grant),
//        o_pwr_detect_* / i_pwr_detect_* detector, o_afe_* / i_afe_* /
//        o_dig_afe_ring_tune tuner AFE, o_grant_ch current grant.
module tuner_ctrl_arb_mc_phy
  import tuner_phy_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DAC_WIDTH = 8,
  parameter int ADC_WIDTH = 8,
  parameter int MAX_SYNC  = 15,
  localparam int SYNC_W   = $clog2(MAX_SYNC + 1),
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CH-1:0]           i_ctrl_active,
  input  logic [NUM_CH-1:0]           i_ctrl_refresh,
  input  logic [NUM_CH-1:0]           i_ctrl_ring_tune_val,
  output logic [NUM_CH-1:0]           o_ctrl_ring_tune_rdy,
  input  logic [NUM_CH*DAC_WIDTH-1:0] i_ctrl_ring_tune,
  output logic [NUM_CH-1:0]           o_ctrl_commit_val,
  input  logic [NUM_CH-1:0]           i_ctrl_commit_rdy,
  output logic [ADC_WIDTH-1:0]        o_ctrl_pwr_commit,
  output logic [DAC_WIDTH-1:0]        o_ctrl_ring_tune_commit,
  input  logic [SYNC_W-1:0]           i_sync_cycle,
  output logic                        o_pwr_detect_active,
  output logic                        o_pwr_detect_refresh,
  input  logic                        i_pwr_detect_update,
  input  logic [ADC_WIDTH-1:0]        i_pwr_detect_data,
  output logic [NUM_CH*DAC_WIDTH-1:0] o_dig_afe_ring_tune,
  output logic                        o_afe_ring_tune_val,
  input  logic                        i_afe_ring_tune_rdy,
  output logic [CH_W-1:0]             o_afe_ch_sel,
  output logic [CH_W-1:0]             o_grant_ch
);

  tuner_phy_ctrl_arb_mc_state_e state, state_nxt;

  logic [CH_W-1:0]      grant, rr_ptr, pick_idx;
  logic                 pick_found;
  logic [SYNC_W-1:0]    cnt, cnt_inc, sync_tgt, tgt_in;
  logic [DAC_WIDTH-1:0] held [NUM_CH];
  logic [DAC_WIDTH-1:0] code_g;
  logic [ADC_WIDTH-1:0] pwr_commit;
  logic [DAC_WIDTH-1:0] tune_commit;
  logic                 det_refresh;
  logic                 abort, fire, upd, commit;

  tuner_rr_picker #(.NUM_CH(NUM_CH)) u_pick (
    .req   (i_ctrl_active),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign code_g = i_ctrl_ring_tune[grant*DAC_WIDTH +: DAC_WIDTH];

  // Losing the controller ends the grant and masks every handshake.
  assign abort = (state != ARB_MC_IDLE) &&
                 (!i_ctrl_active[grant] || i_ctrl_refresh[grant]);

  assign fire = (state == ARB_MC_TUNE) && !abort &&
                i_ctrl_ring_tune_val[grant] && i_afe_ring_tune_rdy;

  assign upd = (state == ARB_MC_SYNC) && !abort && i_pwr_detect_update;

  assign commit = (state == ARB_MC_COMMIT) && !abort &&
                  i_ctrl_commit_rdy[grant];

  assign cnt_inc = (cnt == SYNC_W'(MAX_SYNC)) ? cnt : cnt + 1'b1;

  // A sync depth of zero still waits for one fresh sample.
  always_comb begin
    tgt_in = i_sync_cycle;
    if (i_sync_cycle == '0)
      tgt_in = SYNC_W'(1);
    else if (i_sync_cycle > SYNC_W'(MAX_SYNC))
      tgt_in = SYNC_W'(MAX_SYNC);
  end

  always_comb begin
    state_nxt            = state;
    o_afe_ring_tune_val  = 1'b0;
    o_ctrl_ring_tune_rdy = '0;
    o_ctrl_commit_val    = '0;
    unique case (state)
      ARB_MC_IDLE: begin
        if (pick_found)
          state_nxt = ARB_MC_TUNE;
      end
      ARB_MC_TUNE: begin
        o_afe_ring_tune_val = !abort && i_ctrl_ring_tune_val[grant];
        o_ctrl_ring_tune_rdy[grant] = !abort && i_afe_ring_tune_rdy;
        if (fire)
          state_nxt = ARB_MC_SYNC;
      end
      ARB_MC_SYNC: begin
        if (upd && (cnt_inc >= sync_tgt))
          state_nxt = ARB_MC_COMMIT;
      end
      ARB_MC_COMMIT: begin
        o_ctrl_commit_val[grant] = !abort;
        if (commit)
          state_nxt = ARB_MC_IDLE;
      end
      default: state_nxt = ARB_MC_IDLE;
    endcase
    if (abort)
      state_nxt = ARB_MC_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ARB_MC_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      sync_tgt    <= '0;
      pwr_commit  <= '0;
      tune_commit <= '0;
      det_refresh <= 1'b0;
    end else begin
      state       <= state_nxt;
      det_refresh <= (state == ARB_MC_IDLE) && pick_found;
      if ((state == ARB_MC_IDLE) && pick_found)
        grant <= pick_idx;
      if (abort || commit)
        rr_ptr <= CH_W'(rr_next(int'(grant), NUM_CH));
      if (fire) begin
        cnt      <= '0;
        sync_tgt <= tgt_in;
      end else if (upd) begin
        cnt <= cnt_inc;
      end
      if (i_ctrl_refresh[grant]) begin
        pwr_commit  <= '0;
        tune_commit <= '0;
      end else if (upd) begin
        pwr_commit  <= i_pwr_detect_data;
        tune_commit <= held[grant];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++)
        held[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_ctrl_refresh[c])
          held[c] <= '0;
        else if (fire && (grant == CH_W'(c)))
          held[c] <= code_g;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_dig
    assign o_dig_afe_ring_tune[c*DAC_WIDTH +: DAC_WIDTH] = held[c];
  end

  assign o_ctrl_pwr_commit       = pwr_commit;
  assign o_ctrl_ring_tune_commit = tune_commit;
  assign o_pwr_detect_active     = (state != ARB_MC_IDLE);
  assign o_pwr_detect_refresh    = det_refresh;
  assign o_afe_ch_sel            = grant;
  assign o_grant_ch              = grant;

endmodule
